// File: rtl/fpu_pkg.sv
// Shared widths, flag indices, opcode constants, stage payload structs and the
// leading-zero counter for the pipelined floating-point add/subtract unit.
package fpu_pkg;

  localparam int FPU_E = 8;
  localparam int FPU_M = 23;
  localparam int FPU_W = 1 + FPU_E + FPU_M;
  localparam int SIG_W = FPU_M + 4;
  localparam int SUM_W = FPU_M + 5;
  localparam int LZC_W = $clog2(SIG_W + 1);

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic             sign_a;
    logic [FPU_E-1:0] exp_a;
    logic [FPU_M:0]   sig_a;
    logic [FPU_M:0]   sig_b;
    logic [FPU_E-1:0] diff;
    logic             sub;
    logic             spc;
    logic             spc_inv;
    logic [FPU_W-1:0] spc_res;
  } s12_t;

  typedef struct packed {
    logic             sign_a;
    logic [FPU_E-1:0] exp_a;
    logic [FPU_M:0]   sig_a;
    logic [SIG_W-1:0] al_b;
    logic             sub;
    logic             spc;
    logic             spc_inv;
    logic [FPU_W-1:0] spc_res;
  } s23_t;

  typedef struct packed {
    logic             sign;
    logic [FPU_E-1:0] exp_a;
    logic [SUM_W-1:0] sum;
    logic             spc;
    logic             spc_inv;
    logic [FPU_W-1:0] spc_res;
  } s34_t;

  // Returns SIG_W for an all-zero input, which shifts a zero sum out entirely.
  function automatic logic [LZC_W-1:0] lzc(input logic [SIG_W-1:0] v);
    logic [LZC_W-1:0] n;
    logic             found;
    n     = '0;
    found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_align_shift.sv
// Right shift of a significand into a {significand, guard, round, sticky} field;
// every bit shifted past the sticky position is ORed into sticky.
module fpu_align_shift import fpu_pkg::*; #(
  parameter int WI = FPU_M + 1,
  parameter int SW = FPU_E
) (
  input  logic [WI-1:0] sig,
  input  logic [SW-1:0] shift,
  output logic [WI+2:0] field
);

  localparam int WO = WI + 3;

  logic [WO-1:0] ext;
  logic [WO-1:0] shifted;
  logic [WO-1:0] mask;

  always_comb begin
    ext     = {sig, 3'b000};
    shifted = ext >> shift;
    mask    = ~({WO{1'b1}} << shift);
    if (32'(shift) >= WO - 1) field = {{(WO-1){1'b0}}, |sig};
    else                      field = {shifted[WO-1:1], shifted[0] | (|(ext & mask))};
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Four-stage pipelined FP add/subtract with RNE rounding and exception flags.
// Define FPU_SPECIALS_EN to decode Inf/NaN inputs and drive the invalid flag.
module fpu_addsub_pipe import fpu_pkg::*; #(
  parameter int E = FPU_E,
  parameter int M = FPU_M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             opcode,
  input  logic [E+M:0]     op1,
  input  logic [E+M:0]     op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     result,
  output logic [3:0]       flags
);

  localparam int W    = 1 + E + M;
  localparam int SW   = M + 4;
  localparam int SUMW = M + 5;
  localparam logic signed [E+1:0] EXP_SAT  = (E+2)'((1 << E) - 1);
  localparam logic signed [E+1:0] EXP_ONE  = (E+2)'(1);
  localparam logic signed [E+1:0] EXP_ZERO = '0;

  function automatic logic rne_inc(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [W-1:0] pack_inf(input logic s);
    return {s, {E{1'b1}}, {M{1'b0}}};
  endfunction

  logic adv;
  logic vld_p1, vld_p2, vld_p3;
  s12_t s12_d, s12_p1;
  s23_t s23_d, s23_p2;
  s34_t s34_d, s34_p3;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: unpack, flush denormals, order operands by magnitude
  logic         s1, s2;
  logic [E-1:0] e1, e2;
  logic [M-1:0] m1, m2;
  logic [M:0]   g1, g2;
  logic         swap;
`ifdef FPU_SPECIALS_EN
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  logic nan1, nan2, inf1, inf2;
`endif

  always_comb begin
    s1   = op1[W-1];
    e1   = op1[W-2:M];
    m1   = op1[M-1:0];
    s2   = op2[W-1] ^ (opcode == OP_SUB);
    e2   = op2[W-2:M];
    m2   = op2[M-1:0];
    g1   = (e1 == '0) ? '0 : {1'b1, m1};
    g2   = (e2 == '0) ? '0 : {1'b1, m2};
    swap = {e2, g2[M-1:0]} > {e1, g1[M-1:0]};
    s12_d        = '0;
    s12_d.sign_a = swap ? s2 : s1;
    s12_d.exp_a  = swap ? e2 : e1;
    s12_d.sig_a  = swap ? g2 : g1;
    s12_d.sig_b  = swap ? g1 : g2;
    s12_d.diff   = swap ? e2 - e1 : e1 - e2;
    s12_d.sub    = s1 ^ s2;
`ifdef FPU_SPECIALS_EN
    nan1 = (&e1) && (m1 != '0);
    nan2 = (&e2) && (m2 != '0);
    inf1 = (&e1) && (m1 == '0);
    inf2 = (&e2) && (m2 == '0);
    if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2))) begin
      s12_d.spc     = 1'b1;
      s12_d.spc_inv = 1'b1;
      s12_d.spc_res = QNAN;
    end else if (inf1) begin
      s12_d.spc     = 1'b1;
      s12_d.spc_res = pack_inf(s1);
    end else if (inf2) begin
      s12_d.spc     = 1'b1;
      s12_d.spc_res = pack_inf(s2);
    end
`endif
  end

  // Stage 2: align the smaller significand
  logic [SW-1:0] al_b;

  fpu_align_shift #(.WI(M + 1), .SW(E)) u_align (
    .sig   (s12_p1.sig_b),
    .shift (s12_p1.diff),
    .field (al_b)
  );

  always_comb begin
    s23_d         = '0;
    s23_d.sign_a  = s12_p1.sign_a;
    s23_d.exp_a   = s12_p1.exp_a;
    s23_d.sig_a   = s12_p1.sig_a;
    s23_d.al_b    = al_b;
    s23_d.sub     = s12_p1.sub;
    s23_d.spc     = s12_p1.spc;
    s23_d.spc_inv = s12_p1.spc_inv;
    s23_d.spc_res = s12_p1.spc_res;
  end

  // Stage 3: magnitude add or subtract (A >= B, so the difference is never negative)
  logic [SUMW-1:0] a_ext, b_ext, sum;

  always_comb begin
    a_ext         = {1'b0, s23_p2.sig_a, 3'b000};
    b_ext         = {1'b0, s23_p2.al_b};
    sum           = s23_p2.sub ? a_ext + (~b_ext + 1'b1) : a_ext + b_ext;
    s34_d         = '0;
    s34_d.sum     = sum;
    s34_d.exp_a   = s23_p2.exp_a;
    s34_d.sign    = (sum == '0) ? (!s23_p2.sub && s23_p2.sign_a) : s23_p2.sign_a;
    s34_d.spc     = s23_p2.spc;
    s34_d.spc_inv = s23_p2.spc_inv;
    s34_d.spc_res = s23_p2.spc_res;
  end

  // Stage 4: normalise, round to nearest even, detect exceptions, pack
  logic [LZC_W-1:0]   lz;
  logic [SW-1:0]      nrm;
  logic [M:0]         frac_r;
  logic signed [E+1:0] exp_n, exp_f;
  logic [W-1:0]       res_d;
  logic [3:0]         flg_d;

  always_comb begin
    lz    = lzc(s34_p3.sum[SW-1:0]);
    nrm   = '0;
    exp_n = '0;
    res_d = '0;
    flg_d = '0;
    if (s34_p3.sum[SUMW-1]) begin
      nrm   = {s34_p3.sum[SUMW-1:2], |s34_p3.sum[1:0]};
      exp_n = $signed({2'b00, s34_p3.exp_a}) + EXP_ONE;
    end else begin
      nrm   = s34_p3.sum[SW-1:0] << lz;
      exp_n = $signed({2'b00, s34_p3.exp_a}) - $signed({{(E+2-LZC_W){1'b0}}, lz});
    end
    frac_r = {1'b0, nrm[SW-2:3]} + {{M{1'b0}}, rne_inc(nrm[3], nrm[2], nrm[1], nrm[0])};
    exp_f  = exp_n + $signed({{(E+1){1'b0}}, frac_r[M]});
    if (s34_p3.spc) begin
      res_d              = s34_p3.spc_res;
      flg_d[FLG_INVALID] = s34_p3.spc_inv;
    end else if (!nrm[SW-1]) begin
      res_d = {s34_p3.sign, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_SAT) begin
      res_d               = pack_inf(s34_p3.sign);
      flg_d[FLG_OVERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]  = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      res_d                = '0;
      flg_d[FLG_UNDERFLOW] = 1'b1;
      flg_d[FLG_INEXACT]   = 1'b1;
    end else begin
      res_d              = {s34_p3.sign, exp_f[E-1:0], frac_r[M-1:0]};
      flg_d[FLG_INEXACT] = |nrm[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
      if (vld_p3) begin
        result <= res_d;
        flags  <= flg_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s12_p1 <= s12_d;
      s23_p2 <= s23_d;
      s34_p3 <= s34_d;
    end
  end

endmodule
